// File: rtl/jtcontra_irq_ctrl.sv
// Maskable multi-source interrupt controller for the 6809 main CPU.
// Each source is edge- or level-triggered and is routed to IRQ, FIRQ or NMI.
module jtcontra_irq_ctrl #(
    parameter int unsigned CH         = 4,
    parameter logic [7:0]  EDGE       = 8'hFF,
    parameter logic [7:0]  FIRQ_MAP   = 8'h00,
    parameter logic [7:0]  NMI_MAP    = 8'h00,
    parameter logic [7:0]  RESET_MASK = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic [CH-1:0] src,
    input  logic          dip_pause,
    input  logic          cs,
    input  logic [1:0]    addr,
    input  logic          cpu_rnw,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    dout,
    input  logic          irq_ack,
    input  logic          firq_ack,
    output logic          irq_n,
    output logic          firq_n,
    output logic          nmi_n,
    output logic [2:0]    irq_vec
);
    // State is kept 8 bits wide; bits at CH and above are held at zero.
    localparam logic [7:0] VALID   = 8'((16'd1 << CH) - 16'd1);
    localparam logic [7:0] EDGE_M  = EDGE & VALID;
    localparam logic [7:0] LEVEL_M = ~EDGE & VALID;

    logic [7:0] src_w, src_l, pend, mask, act;
    logic [7:0] nmi_g, firq_g, irq_g, irq_one, firq_one;
    logic [7:0] set_ev, clr, pend_next;
    logic [7:0] pause_m;
    logic       wr;

    assign src_w    = 8'(src) & VALID;
    assign pause_m  = {8{dip_pause}};
    assign act      = pend & mask;
    assign nmi_g    = act & NMI_MAP;
    assign firq_g   = act & FIRQ_MAP & ~NMI_MAP;
    assign irq_g    = act & ~FIRQ_MAP & ~NMI_MAP;
    assign irq_one  = irq_g & (~irq_g + 8'd1);
    assign firq_one = firq_g & (~firq_g + 8'd1);
    assign wr       = cs & ~cpu_rnw & cpu_cen;

    // Acks and W1C only touch edge bits; a coincident set event overrides them.
    always_comb begin
        clr = '0;
        if (irq_ack)             clr = clr | irq_one;
        if (firq_ack)            clr = clr | firq_one;
        if (wr && addr == 2'd1)  clr = clr | cpu_dout;
        clr       = clr & EDGE_M;
        set_ev    = src_w & ~src_l & pause_m & EDGE_M;
        pend_next = (((pend & ~clr) | set_ev) & EDGE_M) | (src_w & pause_m & LEVEL_M);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_l <= VALID;
            pend  <= '0;
            mask  <= RESET_MASK & VALID;
        end else begin
            src_l <= src_w;
            pend  <= pend_next;
            if (wr && addr == 2'd0) mask <= cpu_dout & VALID;
        end
    end

    always_comb begin
        irq_vec = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (irq_g[i-1]) irq_vec = 3'(i - 1);
        end
    end

    assign irq_n  = ~(|irq_g  & dip_pause);
    assign firq_n = ~(|firq_g & dip_pause);
    assign nmi_n  = ~(|nmi_g  & dip_pause);

    always_comb begin
        dout = '0;
        if (cs && cpu_rnw) begin
            case (addr)
                2'd0: dout = mask;
                2'd1: dout = pend;
                2'd2: dout = act;
                default: dout = {4'd0, |irq_g, irq_vec};
            endcase
        end
    end
endmodule

// File: tb/tb_jtcontra_irq_ctrl.sv
// Bench for jtcontra_irq_ctrl: two configurations checked against a per-source
// behavioural model, with directed scenarios and a randomized run.
module tb_jtcontra_irq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1, cpu_cen = 1'b1, dip_pause = 1'b1, cs = 1'b0, cpu_rnw = 1'b1;
    logic irq_ack = 1'b0, firq_ack = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] cpu_dout = 8'd0;
    logic [7:0] src = 8'd0;

    logic [1:0][7:0] dout_o;
    logic [1:0][2:0] vec_o;
    logic [1:0]      irq_n_o, firq_n_o, nmi_n_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtcontra_irq_ctrl #(.CH(4)) ua (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .src(src[3:0]), .dip_pause(dip_pause),
        .cs(cs), .addr(addr), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout), .dout(dout_o[0]),
        .irq_ack(irq_ack), .firq_ack(firq_ack), .irq_n(irq_n_o[0]), .firq_n(firq_n_o[0]),
        .nmi_n(nmi_n_o[0]), .irq_vec(vec_o[0])
    );

    jtcontra_irq_ctrl #(.CH(5), .EDGE(8'h0F), .FIRQ_MAP(8'h04), .NMI_MAP(8'h08),
                        .RESET_MASK(8'hFF)) ub (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .src(src[4:0]), .dip_pause(dip_pause),
        .cs(cs), .addr(addr), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout), .dout(dout_o[1]),
        .irq_ack(irq_ack), .firq_ack(firq_ack), .irq_n(irq_n_o[1]), .firq_n(firq_n_o[1]),
        .nmi_n(nmi_n_o[1]), .irq_vec(vec_o[1])
    );

    // Reference model: one flag per source, rules applied source by source.
    int         ch_c[2]    = '{4, 5};
    logic [7:0] edge_c[2]  = '{8'hFF, 8'h0F};
    logic [7:0] firq_c[2]  = '{8'h00, 8'h04};
    logic [7:0] nmi_c[2]   = '{8'h00, 8'h08};
    logic [7:0] rmask_c[2] = '{8'hFF, 8'hFF};
    bit pm[2][8];
    bit mm[2][8];
    bit lm[2][8];

    function automatic int grp(int k, int i);
        if (nmi_c[k][i]) return 2;
        if (firq_c[k][i]) return 1;
        return 0;
    endfunction

    function automatic int winner(int k, int g);
        for (int i = 0; i < ch_c[k]; i++)
            if (pm[k][i] && mm[k][i] && grp(k, i) == g) return i;
        return -1;
    endfunction

    function automatic logic m_out_n(int k, int g);
        return !(winner(k, g) >= 0 && dip_pause);
    endfunction

    function automatic logic [2:0] m_vec(int k);
        int w;
        w = winner(k, 0);
        return (w < 0) ? 3'd0 : 3'(w);
    endfunction

    function automatic logic [7:0] m_dout(int k);
        logic [7:0] r;
        r = 8'd0;
        if (cs && cpu_rnw) begin
            for (int i = 0; i < ch_c[k]; i++) begin
                case (addr)
                    2'd0: r[i] = mm[k][i];
                    2'd1: r[i] = pm[k][i];
                    2'd2: r[i] = pm[k][i] && mm[k][i];
                    default: ;
                endcase
            end
            if (addr == 2'd3) r = {4'd0, winner(k, 0) >= 0, m_vec(k)};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  wi, wf;
            bit  wr, clr;
            wi = winner(k, 0);
            wf = winner(k, 1);
            wr = cs && !cpu_rnw && cpu_cen;
            for (int i = 0; i < 8; i++) begin
                if (rst || i >= ch_c[k]) begin
                    pm[k][i] = 1'b0;
                    lm[k][i] = 1'b1;
                    mm[k][i] = (i < ch_c[k]) ? rmask_c[k][i] : 1'b0;
                end else begin
                    if (edge_c[k][i]) begin
                        clr = (irq_ack && wi == i) || (firq_ack && wf == i) ||
                              (wr && addr == 2'd1 && cpu_dout[i]);
                        if (src[i] && !lm[k][i] && dip_pause) pm[k][i] = 1'b1;
                        else if (clr) pm[k][i] = 1'b0;
                    end else begin
                        pm[k][i] = src[i] && dip_pause;
                    end
                    if (wr && addr == 2'd0) mm[k][i] = cpu_dout[i];
                    lm[k][i] = src[i];
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cs = 1'b0; cpu_rnw = 1'b1; irq_ack = 1'b0; firq_ack = 1'b0;
        dip_pause = 1'b1; cpu_cen = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; cpu_rnw = 1'b0; addr = a; cpu_dout = d;
        tick();
        cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic test_reset();
        src = 8'h01;
        do_reset();
        tick(); tick();
        checks++; if (irq_n_o[0] !== 1'b1) begin errors++; $display("FAIL reset_irq_n got %b exp 1", irq_n_o[0]); end
        checks++; if (firq_n_o[0] !== 1'b1 || nmi_n_o[0] !== 1'b1) begin errors++; $display("FAIL reset_firq_nmi got %b%b exp 11", firq_n_o[0], nmi_n_o[0]); end
        checks++; if (vec_o[0] !== 3'd0 || dout_o[0] !== 8'h00) begin errors++; $display("FAIL reset_vec_dout got %0d %h exp 0 00", vec_o[0], dout_o[0]); end
        cs = 1'b1; addr = 2'd0; #1;
        checks++; if (dout_o[0] !== 8'h0F) begin errors++; $display("FAIL reset_mask got %h exp 0f", dout_o[0]); end
        cs = 1'b0;
        src = 8'h00; tick();
        checks++; if (irq_n_o[0] !== 1'b1) begin errors++; $display("FAIL fall_irq_n got %b exp 1", irq_n_o[0]); end
        src = 8'h01; tick();
        checks++; if (irq_n_o[0] !== 1'b0 || vec_o[0] !== 3'd0) begin errors++; $display("FAIL edge_irq got %b/%0d exp 0/0", irq_n_o[0], vec_o[0]); end
        cs = 1'b1; addr = 2'd2; #1;
        checks++; if (dout_o[0] !== 8'h01) begin errors++; $display("FAIL edge_reg2 got %h exp 01", dout_o[0]); end
        cs = 1'b0;
    endtask

    task automatic test_priority();
        src = 8'h00; do_reset(); tick();
        src = 8'h0A; tick();
        cs = 1'b1; addr = 2'd1; #1;
        checks++; if (vec_o[0] !== 3'd1 || dout_o[0] !== 8'h0A) begin errors++; $display("FAIL prio_first got %0d %h exp 1 0a", vec_o[0], dout_o[0]); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; #1;
        checks++; if (vec_o[0] !== 3'd3 || dout_o[0] !== 8'h08 || irq_n_o[0] !== 1'b0) begin errors++; $display("FAIL prio_second got %0d %h %b exp 3 08 0", vec_o[0], dout_o[0], irq_n_o[0]); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; #1;
        checks++; if (irq_n_o[0] !== 1'b1 || dout_o[0] !== 8'h00) begin errors++; $display("FAIL prio_done got %b %h exp 1 00", irq_n_o[0], dout_o[0]); end
        cs = 1'b0;
    endtask

    task automatic test_routing();
        src = 8'h00; do_reset(); tick();
        src = 8'h0C; tick(); src = 8'h00;
        checks++; if ({firq_n_o[1], nmi_n_o[1], irq_n_o[1]} !== 3'b001) begin errors++; $display("FAIL route_outputs got %b exp 001", {firq_n_o[1], nmi_n_o[1], irq_n_o[1]}); end
        firq_ack = 1'b1; tick(); firq_ack = 1'b0;
        checks++; if ({firq_n_o[1], nmi_n_o[1]} !== 2'b10) begin errors++; $display("FAIL route_firq_ack got %b exp 10", {firq_n_o[1], nmi_n_o[1]}); end
        irq_ack = 1'b1; firq_ack = 1'b1; tick(); irq_ack = 1'b0; firq_ack = 1'b0;
        checks++; if (nmi_n_o[1] !== 1'b0) begin errors++; $display("FAIL route_nmi_hold got %b exp 0", nmi_n_o[1]); end
        cpu_write(2'd1, 8'h08);
        checks++; if (nmi_n_o[1] !== 1'b1) begin errors++; $display("FAIL route_w1c got %b exp 1", nmi_n_o[1]); end
        src = 8'h10; tick();
        checks++; if (irq_n_o[1] !== 1'b0 || vec_o[1] !== 3'd4) begin errors++; $display("FAIL level_set got %b/%0d exp 0/4", irq_n_o[1], vec_o[1]); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        checks++; if (irq_n_o[1] !== 1'b0) begin errors++; $display("FAIL level_ack got %b exp 0", irq_n_o[1]); end
        src = 8'h00; tick();
        checks++; if (irq_n_o[1] !== 1'b1) begin errors++; $display("FAIL level_drop got %b exp 1", irq_n_o[1]); end
    endtask

    task automatic test_mask();
        src = 8'h00; do_reset(); tick();
        cpu_write(2'd0, 8'h00);
        src = 8'h01; tick();
        cs = 1'b1; addr = 2'd1; #1;
        checks++; if (irq_n_o[0] !== 1'b1 || dout_o[0] !== 8'h01) begin errors++; $display("FAIL mask_off got %b %h exp 1 01", irq_n_o[0], dout_o[0]); end
        cs = 1'b0;
        cpu_write(2'd0, 8'h01);
        checks++; if (irq_n_o[0] !== 1'b0) begin errors++; $display("FAIL mask_on got %b exp 0", irq_n_o[0]); end
        cpu_cen = 1'b0; cpu_write(2'd0, 8'h00); cpu_cen = 1'b1;
        checks++; if (irq_n_o[0] !== 1'b0) begin errors++; $display("FAIL mask_cen got %b exp 0", irq_n_o[0]); end
    endtask

    task automatic test_pause();
        src = 8'h00; do_reset(); tick();
        dip_pause = 1'b0; src = 8'h02; tick(); src = 8'h00; tick();
        dip_pause = 1'b1; cs = 1'b1; addr = 2'd1; #1;
        checks++; if (irq_n_o[0] !== 1'b1 || dout_o[0] !== 8'h00) begin errors++; $display("FAIL pause_nolatch got %b %h exp 1 00", irq_n_o[0], dout_o[0]); end
        cs = 1'b0;
        src = 8'h01; tick();
        dip_pause = 1'b0; #1;
        checks++; if ({irq_n_o[0], firq_n_o[0], nmi_n_o[0]} !== 3'b111) begin errors++; $display("FAIL pause_outputs got %b exp 111", {irq_n_o[0], firq_n_o[0], nmi_n_o[0]}); end
        tick(); tick();
        dip_pause = 1'b1; #1;
        checks++; if (irq_n_o[0] !== 1'b0) begin errors++; $display("FAIL pause_resume got %b exp 0", irq_n_o[0]); end
    endtask

    task automatic test_back_to_back();
        src = 8'h00; do_reset(); tick();
        src = 8'h01; tick(); src = 8'h00; tick();
        src = 8'h01; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        cs = 1'b1; addr = 2'd1; #1;
        checks++; if (dout_o[0] !== 8'h01 || irq_n_o[0] !== 1'b0) begin errors++; $display("FAIL set_wins got %h %b exp 01 0", dout_o[0], irq_n_o[0]); end
        cs = 1'b0; src = 8'h06; tick();
        rst = 1'b1; cpu_cen = 1'b0; tick(); cpu_cen = 1'b1;
        checks++; if ({irq_n_o[0], firq_n_o[0], nmi_n_o[0]} !== 3'b111 || vec_o[0] !== 3'd0) begin errors++; $display("FAIL midrst_out got %b %0d exp 111 0", {irq_n_o[0], firq_n_o[0], nmi_n_o[0]}, vec_o[0]); end
        checks++; if ({irq_n_o[1], firq_n_o[1], nmi_n_o[1]} !== 3'b111 || dout_o[1] !== 8'h00) begin errors++; $display("FAIL midrst_b got %b %h exp 111 00", {irq_n_o[1], firq_n_o[1], nmi_n_o[1]}, dout_o[1]); end
        rst = 1'b0; src = 8'h00;
    endtask

    task automatic test_random();
        src = 8'h00; do_reset(); tick();
        for (int c = 0; c < 600; c++) begin
            src       = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom) & 8'h1F);
            rst       = ($urandom_range(0, 99) == 0);
            cpu_cen   = ($urandom_range(0, 3) != 0);
            dip_pause = ($urandom_range(0, 7) != 0);
            cs        = $urandom_range(0, 1);
            cpu_rnw   = ($urandom_range(0, 3) != 0);
            addr      = 2'($urandom_range(0, 3));
            cpu_dout  = 8'($urandom);
            irq_ack   = ($urandom_range(0, 3) == 0);
            firq_ack  = ($urandom_range(0, 3) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++; if (irq_n_o[k] !== m_out_n(k, 0)) begin errors++; $display("FAIL rand_irq_n dut%0d cyc%0d got %b exp %b", k, c, irq_n_o[k], m_out_n(k, 0)); end
                checks++; if (firq_n_o[k] !== m_out_n(k, 1)) begin errors++; $display("FAIL rand_firq_n dut%0d cyc%0d got %b exp %b", k, c, firq_n_o[k], m_out_n(k, 1)); end
                checks++; if (nmi_n_o[k] !== m_out_n(k, 2)) begin errors++; $display("FAIL rand_nmi_n dut%0d cyc%0d got %b exp %b", k, c, nmi_n_o[k], m_out_n(k, 2)); end
                checks++; if (vec_o[k] !== m_vec(k)) begin errors++; $display("FAIL rand_vec dut%0d cyc%0d got %0d exp %0d", k, c, vec_o[k], m_vec(k)); end
                checks++; if (dout_o[k] !== m_dout(k)) begin errors++; $display("FAIL rand_dout dut%0d cyc%0d got %h exp %h", k, c, dout_o[k], m_dout(k)); end
            end
            tick();
        end
        rst = 1'b0; cs = 1'b0; cpu_rnw = 1'b1; irq_ack = 1'b0; firq_ack = 1'b0;
        dip_pause = 1'b1; cpu_cen = 1'b1;
    endtask

    initial begin
        tick();
        test_reset();
        test_priority();
        test_routing();
        test_mask();
        test_pause();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtcontra_irq_ctrl.md
# jtcontra_irq_ctrl

Parametrised interrupt controller for the main 6809 CPU. It replaces the single-edge interrupt flip-flop with CH maskable sources. Each source is edge- or level-triggered and routed to IRQ, FIRQ or NMI, with a CPU register window for mask, pending and vector. It sits between the video/timer interrupt sources and the jtframe_sys6809 instance.

## Interface
Parameters:
- CH, 4: number of sources, 1..8.
- EDGE, 8'hFF: bit i=1 makes source i edge-triggered; 0 makes it level-triggered.
- FIRQ_MAP, 8'h00: bit i=1 routes source i to FIRQ.
- NMI_MAP, 8'h00: bit i=1 routes source i to NMI. NMI_MAP has priority over FIRQ_MAP. Unrouted sources go to IRQ.
- RESET_MASK, 8'hFF: mask register value after reset.

Ports:
- clk, in, 1: system clock, 24 MHz.
- rst, in, 1: synchronous, active-high reset.
- cpu_cen, in, 1: CPU clock enable; qualifies register writes only.
- src, in, CH: interrupt sources, active high (caller inverts active-low lines such as gfx_irqn).
- dip_pause, in, 1: 0 = paused.
- cs, in, 1: register window select.
- addr, in, 2: register index.
- cpu_rnw, in, 1: 1 = read.
- cpu_dout, in, 8: CPU write data.
- dout, out, 8: read data.
- irq_ack, in, 1: one-cycle pulse from the CPU on IRQ vector fetch.
- firq_ack, in, 1: same, for FIRQ.
- irq_n, out, 1: IRQ to the CPU, active low.
- firq_n, out, 1: FIRQ to the CPU, active low.
- nmi_n, out, 1: NMI to the CPU, active low.
- irq_vec, out, 3: index of the winning IRQ-group source.

## Operation
- State: src_l[CH] (previous sample), pend[CH], mask[CH]. All update on every clk; they are not gated by cpu_cen, so single-cycle source pulses are never lost.
- Edge source i: set-event = src[i] & ~src_l[i] & dip_pause. A set-event sets pend[i]. pend[i] clears only through an ack or a W1C write.
- Level source i: pend[i] <= src[i] & dip_pause every cycle. Acks and W1C writes do not affect it.
- Active: act = pend & mask. Groups: nmi = act & NMI_MAP; firq = act & FIRQ_MAP & ~NMI_MAP; irq = the remaining bits.
- irq_n = ~(|irq & dip_pause). firq_n and nmi_n follow the same rule for their groups. All three are combinational from registers.
- Priority: the lowest index wins. irq_vec = index of the lowest set bit of irq, or 0 when irq is empty.
- irq_ack clears the winning IRQ-group edge source. firq_ack clears the lowest set bit of firq. An ack with an empty group, or whose winner is a level source, has no effect.
- NMI-group edge sources clear only through W1C.
- Registers (write strobe = cs & ~cpu_rnw & cpu_cen):
  - 0: mask, R/W.
  - 1: pend. A read returns pend. A write clears every edge bit where cpu_dout=1 (W1C).
  - 2: act, read-only.
  - 3: read returns {4'd0, |irq, irq_vec}. Writes are ignored.
- Bits at CH and above read as 0.
- dout is combinational: the selected register when cs & cpu_rnw, otherwise 8'h00.
- Simultaneous set-event and clear (ack or W1C) on the same bit in the same cycle: set wins, and the bit stays pending.
- Paused: no new edges latch and all outputs deassert. Existing pend bits are retained and reappear when dip_pause returns to 1.

## Timing
- Reset values: src_l = all ones (a source already high at reset release does not trigger), pend = 0, mask = RESET_MASK. irq_n, firq_n and nmi_n are 1, irq_vec = 0, dout = 0.
- Latency: a set-event sampled at clk edge N sets pend after N. The corresponding _n output is low during cycle N+1.
- Ack: an irq_ack high at edge N clears the bit after N. irq_n rises in cycle N+1 if no other IRQ-group bit is active; otherwise irq_vec moves to the next winner in cycle N+1.
- A mask write takes effect on outputs in the cycle after the write strobe edge.
- A source that stays high produces exactly one pend set per rising edge.
- rst asserted mid-operation returns all state to reset values on the next clk edge, regardless of cpu_cen.

## Test plan
- Reset, defaults, src = 4'b0001 held from reset -> no interrupt. Drop src[0] to 0 and raise it to 1 again -> irq_n low exactly 1 cycle after the edge sample, irq_vec = 0, reg2 reads 8'h01.
- src[1] and src[3] rise in the same cycle, then two irq_ack pulses -> irq_vec = 1, then 3. irq_n rises 1 cycle after the second ack. reg1 reads 8'h0A, then 8'h08, then 8'h00.
- FIRQ_MAP = 8'h04, NMI_MAP = 8'h08: pulse src[2] and src[3] -> firq_n = 0, nmi_n = 0, irq_n = 1. firq_ack clears bit 2. W1C write 8'h08 to reg1 raises nmi_n.
- Write mask = 8'h00, then pulse src[0] -> irq_n stays 1 and reg1 = 8'h01. Write mask = 8'h01 -> irq_n low the following cycle.
- Hold dip_pause = 0 and pulse src[1] -> nothing latches and outputs stay high. Set pend[0] before pausing -> irq_n high while paused, low again when dip_pause = 1.
- Drive a src[0] rising edge in the same cycle as an irq_ack targeting bit 0 -> pend[0] stays 1. Assert rst mid-sequence -> all outputs return to reset values on the next edge.
